// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// The release input is named release_gnt because release is a reserved word.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       release_gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] last_r;
    logic [2:0] last_s;
    logic [3:0] hold_r;
    logic [3:0] hold_s;
    logic [2:0] gnt_idx_s;
    logic       gnt_valid_s;
    logic       timeout_s;
    logic       rel_s;
    logic       hold_max_s;
    logic [2:0] pick_s;

    // Search starts just after the last grantee, so that grantee is considered last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] l);
        logic [2:0] idx;
        logic       found;
        rr_pick = l;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = l + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        hold_s      = hold_r;
        gnt_idx_s   = gnt_idx;
        gnt_valid_s = gnt_valid;
        timeout_s   = 1'b0;
        pick_s      = rr_pick(req, last_r);
        rel_s       = release_gnt || !req[gnt_idx];
        hold_max_s  = (hold_r == 4'(HOLD_MAX));
        case (state_r)
            ST_IDLE: begin
                if (req != 8'h00) begin
                    state_s     = ST_GRANT;
                    gnt_idx_s   = pick_s;
                    gnt_valid_s = 1'b1;
                    hold_s      = 4'd1;
                end else begin
                    gnt_valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_s || hold_max_s) begin
                    // A coincident normal release wins over the timeout.
                    state_s     = ST_IDLE;
                    last_s      = gnt_idx;
                    gnt_valid_s = 1'b0;
                    timeout_s   = hold_max_s && !rel_s;
                end else if (!hold_max_s) begin
                    hold_s = hold_r + 4'd1;
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything, even mid-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= 3'd7;
            hold_r    <= 4'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            hold_r    <= hold_s;
            gnt_idx   <= gnt_idx_s;
            gnt_valid <= gnt_valid_s;
            timeout   <= timeout_s;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 with hand-computed expectations.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       release_gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks_r;
    int failures_r;
    int vcnt;
    logic [2:0] exp_seq [4];

    rr_arbiter8 #(.HOLD_MAX(15)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .release_gnt(release_gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        checks_r    = 0;
        failures_r  = 0;
        rst         = 1'b1;
        req         = 8'h00;
        release_gnt = 1'b0;
        exp_seq[0] = 3'd6; exp_seq[1] = 3'd7; exp_seq[2] = 3'd0; exp_seq[3] = 3'd1;
        tick;
        tick;
        check_eq("rst_valid", 8'(gnt_valid), 8'h00);
        check_eq("rst_idx", 8'(gnt_idx), 8'h00);
        check_eq("rst_timeout", 8'(timeout), 8'h00);

        // Two requesters: 0 first after reset, then 7, then 0 again.
        rst = 1'b0;
        req = 8'h81;
        tick;
        check_eq("first_idx", 8'(gnt_idx), 8'h00);
        check_eq("first_valid", 8'(gnt_valid), 8'h01);
        tick;
        release_gnt = 1'b1;
        tick;
        release_gnt = 1'b0;
        check_eq("rel_valid", 8'(gnt_valid), 8'h00);
        check_eq("rel_timeout", 8'(timeout), 8'h00);
        tick;
        check_eq("second_idx", 8'(gnt_idx), 8'h07);
        check_eq("second_valid", 8'(gnt_valid), 8'h01);
        release_gnt = 1'b1;
        tick;
        release_gnt = 1'b0;
        tick;
        check_eq("third_idx", 8'(gnt_idx), 8'h00);
        release_gnt = 1'b1;
        tick;
        release_gnt = 1'b0;
        req = 8'h00;
        tick;
        check_eq("idle_hold_idx", 8'(gnt_idx), 8'h00);

        // Single requester held: 15 grant cycles, timeout pulse, re-grant.
        req = 8'h04;
        tick;
        check_eq("to_idx", 8'(gnt_idx), 8'h02);
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (gnt_valid) vcnt++;
            tick;
        end
        check_eq("to_len", 8'(vcnt), 8'd15);
        check_eq("to_valid", 8'(gnt_valid), 8'h00);
        check_eq("to_pulse", 8'(timeout), 8'h01);
        tick;
        check_eq("to_pulse_end", 8'(timeout), 8'h00);
        check_eq("to_regrant", 8'(gnt_valid), 8'h01);
        check_eq("to_regrant_idx", 8'(gnt_idx), 8'h02);
        req = 8'h00;
        tick;
        check_eq("drop_timeout", 8'(timeout), 8'h00);
        tick;

        // Wrap-around from 5 with all requesters active.
        req = 8'h20;
        tick;
        check_eq("grant5", 8'(gnt_idx), 8'h05);
        req = 8'hFF;
        release_gnt = 1'b1;
        tick;
        release_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_eq("wrap_idx", 8'(gnt_idx), 8'(exp_seq[i]));
            release_gnt = 1'b1;
            tick;
            release_gnt = 1'b0;
        end
        req = 8'h00;
        tick;

        // Dropped request ends grant 3 normally and records last=3.
        req = 8'h08;
        tick;
        check_eq("grant3", 8'(gnt_idx), 8'h03);
        req = 8'h00;
        tick;
        check_eq("drop3_valid", 8'(gnt_valid), 8'h00);
        check_eq("drop3_timeout", 8'(timeout), 8'h00);
        req = 8'h18;
        tick;
        check_eq("after3_idx", 8'(gnt_idx), 8'h04);

        // Reset aborts grant 4; search restarts at 0.
        rst = 1'b1;
        tick;
        check_eq("rst4_valid", 8'(gnt_valid), 8'h00);
        check_eq("rst4_idx", 8'(gnt_idx), 8'h00);
        check_eq("rst4_timeout", 8'(timeout), 8'h00);
        rst = 1'b0;
        req = 8'h11;
        tick;
        check_eq("rst4_regrant", 8'(gnt_idx), 8'h00);

        // Release coinciding with hold==HOLD_MAX is a normal release.
        req = 8'h01;
        repeat (14) tick;
        check_eq("hm_still_valid", 8'(gnt_valid), 8'h01);
        release_gnt = 1'b1;
        tick;
        check_eq("hm_valid", 8'(gnt_valid), 8'h00);
        check_eq("hm_timeout", 8'(timeout), 8'h00);
        // Release while idle does not block a new grant.
        tick;
        check_eq("idle_rel_valid", 8'(gnt_valid), 8'h01);
        release_gnt = 1'b0;
        req = 8'h00;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter: HOLD_MAX, default 15, maximum cycles a grant is held before forced release (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port: req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-005 SHALL have port: release  input  1  current grantee finished, sampled only while gnt_valid=1.
REQ-006 SHALL have port: gnt_idx  output  3  binary index of granted requester; bit2/bit1/bit0 drive the 3-to-8 decoder a2/a1/a0 inputs directly.
REQ-007 SHALL have port: gnt_valid  output  1  gnt_idx holds an active grant.
REQ-008 SHALL have port: timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-010 SHALL keep an internal 3-bit pointer last = index of the most recently completed grant.
REQ-011 In IDLE with req!=0, SHALL select the first set bit searching last+1, last+2, ... mod 8, wrapping 7->0, with last itself searched last.
REQ-012 SHALL register the selected index into gnt_idx, set gnt_valid=1 and enter GRANT on the same edge: req sampled at edge N gives gnt_valid=1 in the cycle after edge N.
REQ-013 In IDLE with req==0, SHALL remain in IDLE with gnt_idx unchanged.
REQ-014 gnt_idx SHALL be stable for the whole GRANT period and SHALL retain its last value in IDLE.
REQ-015 SHALL keep a 4-bit hold counter: loaded with 1 on GRANT entry, incremented each further GRANT cycle, saturating at HOLD_MAX.
REQ-016 In GRANT, SHALL exit to IDLE at the next edge when any of: release=1; req[gnt_idx]=0; hold counter==HOLD_MAX.
REQ-017 On every GRANT exit, SHALL set last=gnt_idx and clear gnt_valid; IDLE SHALL last at least one cycle (no back-to-back grants).
REQ-018 SHALL assert timeout for exactly the one cycle following a GRANT exit caused solely by hold counter==HOLD_MAX.
REQ-019 When release=1 or req[gnt_idx]=0 coincides with hold counter==HOLD_MAX, SHALL treat exit as normal release, timeout=0.
REQ-020 Changes on req bits other than gnt_idx during GRANT SHALL have no effect until the next IDLE cycle.
REQ-021 release asserted in IDLE SHALL be ignored.
REQ-022 With a single requester held high continuously, SHALL re-grant it every HOLD_MAX+1 cycles (HOLD_MAX grant cycles, 1 idle cycle).

Reset
REQ-023 On rst=1 at a rising edge: state=IDLE, gnt_idx=3'b000, gnt_valid=0, timeout=0, last=3'd7, hold counter=0.
REQ-024 rst SHALL override all other inputs, including mid-GRANT; no timeout pulse generated by a reset-aborted grant.
REQ-025 The first search after reset SHALL begin at index 0.

Verification
REQ-026 After reset, req=8'b1000_0001 held -> grant 0 first, release after 2 cycles, 1 idle cycle, then grant 7, then grant 0 again.
REQ-027 req=8'b0000_0100 held, release=0, HOLD_MAX=15 -> gnt_idx=2 with gnt_valid=1 for 15 cycles, timeout=1 for 1 cycle, re-grant 2 after 1 idle cycle.
REQ-028 Granted to 5, req=8'b1111_1111, release pulse -> next grants 6, 7, 0, 1 in order (wrap-around).
REQ-029 Grant to 3 active, req[3] dropped while release=0 -> gnt_valid=0 next cycle, timeout=0, last=3.
REQ-030 release=1 on the cycle hold counter==HOLD_MAX -> gnt_valid=0 next cycle, timeout stays 0.
REQ-031 rst=1 during GRANT of index 4 -> next cycle gnt_valid=0, gnt_idx=0, timeout=0; with req=8'b0001_0001, grant 0 before 4.
